// File: rtl/uart_tx_if.sv
// Byte-side handshake and serial-line bundle for uart_tx.
// The master supplies the byte and valid strobe; the slave (the transmitter)
// reports line activity, the serial line itself and the completion pulse.
interface uart_tx_if;
    logic       i_Tx_DV;
    logic [7:0] i_Tx_Byte;
    logic       o_Tx_Active;
    logic       o_Tx_Serial;
    logic       o_Tx_Done;

    modport master (
        output i_Tx_DV,
        output i_Tx_Byte,
        input  o_Tx_Active,
        input  o_Tx_Serial,
        input  o_Tx_Done
    );

    modport slave (
        input  i_Tx_DV,
        input  i_Tx_Byte,
        output o_Tx_Active,
        output o_Tx_Serial,
        output o_Tx_Done
    );
endinterface

// File: rtl/uart_tx.sv
// UART transmitter: start bit, 8 data bits LSB first, optional parity bit,
// one or two stop bits, then a single-cycle completion pulse.
// Every output comes straight from a flop, so the serial line cannot glitch.
module uart_tx #(
    parameter int CLKS_PER_BIT = 87,
    parameter int PARITY_EN    = 0,
    parameter int PARITY_ODD   = 0,
    parameter int STOP_BITS    = 1
) (
    input  logic     i_Clock,
    input  logic     i_Reset,
    uart_tx_if.slave tx
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        PARITY  = 3'd3,
        STOP    = 3'd4,
        CLEANUP = 3'd5
    } state_t;

    localparam logic [15:0] LAST_CLK  = 16'(CLKS_PER_BIT - 1);
    localparam logic [2:0]  LAST_STOP = 3'(STOP_BITS - 1);
    localparam logic        PAR_ODD   = (PARITY_ODD != 0);
    localparam bit          HAS_PAR   = (PARITY_EN != 0);

    state_t      state, state_n;
    logic [15:0] clk_cnt, clk_cnt_n;
    logic [2:0]  bit_idx, bit_idx_n;
    logic [7:0]  byte_q, byte_n;
    logic        par_q, par_n;
    logic        serial_q, serial_n;
    logic        active_q, active_n;
    logic        done_q, done_n;
    logic        bit_last;

    assign bit_last       = (clk_cnt == LAST_CLK);
    assign tx.o_Tx_Serial = serial_q;
    assign tx.o_Tx_Active = active_q;
    assign tx.o_Tx_Done   = done_q;

    // State, counters, latched byte and all outputs are registered together.
    always_ff @(posedge i_Clock or posedge i_Reset) begin
        if (i_Reset) begin
            state    <= IDLE;
            clk_cnt  <= '0;
            bit_idx  <= '0;
            byte_q   <= '0;
            par_q    <= 1'b0;
            serial_q <= 1'b1;
            active_q <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            state    <= state_n;
            clk_cnt  <= clk_cnt_n;
            bit_idx  <= bit_idx_n;
            byte_q   <= byte_n;
            par_q    <= par_n;
            serial_q <= serial_n;
            active_q <= active_n;
            done_q   <= done_n;
        end
    end

    // Next state plus the output values that must appear in the next cycle;
    // the line level for a new bit is chosen on the edge that enters that bit.
    always_comb begin
        state_n   = state;
        clk_cnt_n = clk_cnt;
        bit_idx_n = bit_idx;
        byte_n    = byte_q;
        par_n     = par_q;
        serial_n  = 1'b1;
        active_n  = 1'b0;
        done_n    = 1'b0;

        case (state)
            IDLE: begin
                clk_cnt_n = '0;
                bit_idx_n = '0;
                if (tx.i_Tx_DV) begin
                    byte_n   = tx.i_Tx_Byte;
                    par_n    = (^tx.i_Tx_Byte) ^ PAR_ODD;
                    state_n  = START;
                    serial_n = 1'b0;
                    active_n = 1'b1;
                end
            end

            START: begin
                active_n = 1'b1;
                serial_n = 1'b0;
                if (bit_last) begin
                    clk_cnt_n = '0;
                    state_n   = DATA;
                    serial_n  = byte_q[0];
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end

            DATA: begin
                active_n = 1'b1;
                serial_n = byte_q[bit_idx];
                if (bit_last) begin
                    clk_cnt_n = '0;
                    if (bit_idx == 3'd7) begin
                        bit_idx_n = '0;
                        if (HAS_PAR) begin
                            state_n  = PARITY;
                            serial_n = par_q;
                        end else begin
                            state_n  = STOP;
                            serial_n = 1'b1;
                        end
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        serial_n  = byte_q[bit_idx + 3'd1];
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end

            PARITY: begin
                active_n = 1'b1;
                serial_n = par_q;
                if (bit_last) begin
                    clk_cnt_n = '0;
                    state_n   = STOP;
                    serial_n  = 1'b1;
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end

            STOP: begin
                active_n = 1'b1;
                serial_n = 1'b1;
                if (bit_last) begin
                    clk_cnt_n = '0;
                    if (bit_idx == LAST_STOP) begin
                        bit_idx_n = '0;
                        state_n   = CLEANUP;
                        active_n  = 1'b0;
                        done_n    = 1'b1;
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                    end
                end else begin
                    clk_cnt_n = clk_cnt + 16'd1;
                end
            end

            CLEANUP: begin
                state_n = IDLE;
            end

            default: begin
                state_n   = IDLE;
                clk_cnt_n = '0;
                bit_idx_n = '0;
            end
        endcase
    end

endmodule
